// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS control unit
// Contents: state enum, ALU operation class, opcode/func constants,
//           ALUControl codes, RegDst/ALUSrcB/PCSrc select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
        JR      = 4'd12
    } stateType;

    // Which decode table the ALU decoder should apply this cycle.
    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_IMM   = 2'd3
    } aluClassType;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // R-type ALU functions that go through RTYPEEX (jr has its own path).
    function automatic logic isRtypeAluFunc(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
            FN_NOR, FN_SLT, FN_SLL, FN_SRL, FN_SRA: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - op/func/class to ALUControl and ExS
// Ports: aluClass (which table applies), op, func -> aluControl, exS.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluClassType aluClass,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    output logic [3:0]  aluControl,
    output logic        exS
);

    always_comb begin
        aluControl = ALU_ADD;
        exS        = 1'b1;
        case (aluClass)
            CLS_SUB: aluControl = ALU_SUB;
            CLS_RTYPE: begin
                case (func)
                    FN_ADD, FN_ADDU: aluControl = ALU_ADD;
                    FN_SUB, FN_SUBU: aluControl = ALU_SUB;
                    FN_AND:          aluControl = ALU_AND;
                    FN_OR:           aluControl = ALU_OR;
                    FN_XOR:          aluControl = ALU_XOR;
                    FN_NOR:          aluControl = ALU_NOR;
                    FN_SLT:          aluControl = ALU_SLT;
                    FN_SLL:          aluControl = ALU_SLL;
                    FN_SRL:          aluControl = ALU_SRL;
                    FN_SRA:          aluControl = ALU_SRA;
                    default:         aluControl = ALU_ADD;
                endcase
            end
            CLS_IMM: begin
                case (op)
                    OP_SLTI: aluControl = ALU_SLT;
                    OP_ANDI: begin aluControl = ALU_AND; exS = 1'b0; end
                    OP_ORI:  begin aluControl = ALU_OR;  exS = 1'b0; end
                    OP_XORI: begin aluControl = ALU_XOR; exS = 1'b0; end
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with retirement counter
// Inputs:  CLK, Reset_n (async, active-low), op, func, Zero.
// Outputs: datapath controls (PCEn, IorD, MemWrite, IRWrite, RegDst, Mem2Reg,
//          RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, ExS), debug State,
//          IllegalOp, Retire and the wrapping InstrCount.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               Zero,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic               Mem2Reg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic               ExS,
    output logic [3:0]         State,
    output logic               IllegalOp,
    output logic               Retire,
    output logic [COUNT_W-1:0] InstrCount
);

    stateType    state, nextState;
    aluClassType aluClass;
    logic        pcEnRaw, irWriteRaw, memWriteRaw, regWriteRaw;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= FETCH;
            InstrCount <= '0;
        end else begin
            state <= nextState;
            if (Retire) InstrCount <= InstrCount + COUNT_W'(1);
        end
    end

    always_comb begin
        nextState   = FETCH;
        pcEnRaw     = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        IorD        = 1'b0;
        RegDst      = REGDST_RT;
        Mem2Reg     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = PCSRC_ALU;
        aluClass    = CLS_ADD;
        IllegalOp   = 1'b0;
        Retire      = 1'b0;
        case (state)
            FETCH: begin
                irWriteRaw = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                pcEnRaw    = 1'b1;
                nextState  = DECODE;
            end
            DECODE: begin
                // ALU precomputes PC+4 + (SignImm<<2) so BRANCH can use ALUOut.
                ALUSrcB = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW:   nextState = MEMADR;
                    OP_BEQ, OP_BNE: nextState = BRANCH;
                    OP_J:           nextState = JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:
                                    nextState = IMMEX;
                    OP_RTYPE: begin
                        if (func == FN_JR)             nextState = JR;
                        else if (isRtypeAluFunc(func)) nextState = RTYPEEX;
                        else                           IllegalOp = 1'b1;
                    end
                    default: IllegalOp = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nextState = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD      = 1'b1;
                nextState = MEMWB;
            end
            MEMWB: begin
                Mem2Reg     = 1'b1;
                regWriteRaw = 1'b1;
                Retire      = 1'b1;
            end
            MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
                Retire      = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA   = 1'b1;
                aluClass  = CLS_RTYPE;
                nextState = RTYPEWB;
            end
            RTYPEWB: begin
                RegDst      = REGDST_RD;
                regWriteRaw = 1'b1;
                Retire      = 1'b1;
            end
            BRANCH: begin
                // Zero comes straight from this cycle's subtract.
                ALUSrcA  = 1'b1;
                aluClass = CLS_SUB;
                PCSrc    = PCSRC_ALUOUT;
                pcEnRaw  = (op == OP_BEQ) ? Zero : ~Zero;
                Retire   = 1'b1;
            end
            IMMEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                aluClass  = CLS_IMM;
                nextState = IMMWB;
            end
            IMMWB: begin
                regWriteRaw = 1'b1;
                Retire      = 1'b1;
            end
            JUMP: begin
                PCSrc   = PCSRC_JUMP;
                pcEnRaw = 1'b1;
                Retire  = 1'b1;
            end
            JR: begin
                // rt is $0, so A + B is just the register target.
                ALUSrcA = 1'b1;
                pcEnRaw = 1'b1;
                Retire  = 1'b1;
            end
            default: nextState = FETCH;
        endcase
    end

    alu_decoder uAluDecoder (
        .aluClass   (aluClass),
        .op         (op),
        .func       (func),
        .aluControl (ALUControl),
        .exS        (ExS)
    );

    // Write strobes are masked while reset is held so nothing commits.
    assign PCEn     = pcEnRaw     & Reset_n;
    assign IRWrite  = irWriteRaw  & Reset_n;
    assign MemWrite = memWriteRaw & Reset_n;
    assign RegWrite = regWriteRaw & Reset_n;
    assign State    = state;

endmodule
